// File: rtl/adder_pkg.sv
// Constants shared by the 12/24-bit modular adder and its batch scheduler:
// adder modes, moduli, the B-high lane shift and the scheduler state encoding.
package adder_pkg;

    localparam logic [1:0] MODE_K2  = 2'd0;
    localparam logic [1:0] MODE_K4  = 2'd1;
    localparam logic [1:0] MODE_D   = 2'd2;
    localparam logic [1:0] MODE_ILL = 2'd3;

    localparam int KQ        = 3329;
    localparam int DQ        = 8380417;
    localparam int SHIFT_LAT = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    function automatic logic mode_legal(input logic [1:0] m);
        return m != MODE_ILL;
    endfunction

endpackage

// File: rtl/adder1_delay_line.sv
// Width/depth-parameterised shift register with synchronous reset.
// DEPTH=0 is a straight wire; occ reports any set VLD_BIT inside the stages.
module adder1_delay_line #(
    parameter int W       = 8,
    parameter int DEPTH   = 6,
    parameter int VLD_BIT = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         occ
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q   = d;
            assign occ = 1'b0;
        end else begin : g_pipe
            logic [DEPTH-1:0][W-1:0] stg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stg <= '0;
                end else begin
                    stg[0] <= d;
                    for (int i = 1; i < DEPTH; i++)
                        stg[i] <= stg[i-1];
                end
            end

            always_comb begin
                occ = 1'b0;
                for (int i = 0; i < DEPTH; i++)
                    occ = occ | stg[i][VLD_BIT];
            end

            assign q = stg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/adder1_sched.sv
// Batch scheduler for the shared modular adder: latches mode/direction per batch,
// aligns lanes around the adder's B-high shift, registers results. Option: ADDER1_SCHED_PERF_EN.
module adder1_sched #(
    parameter int DATA_W    = 24,
    parameter int SHIFT_LAT = 6,
    parameter int LEN_W     = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic              cmd_intt,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_sel_1,
    output logic [1:0]        add_mode,
    input  logic [DATA_W-1:0] add_sum,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef ADDER1_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_elems
`endif
);
    import adder_pkg::*;

    localparam int HALF_W = DATA_W / 2;
    localparam int DL_W   = DATA_W + HALF_W + 2;

    sched_state_t      state_q, state_d;
    logic [1:0]        mode_q;
    logic              intt_q;
    logic [LEN_W-1:0]  len_q, cnt_q, cnt_inc;
    logic              cmd_acc, cmd_bad, cmd_go;
    logic              acc, acc_last;
    logic [DL_W-1:0]   dl_d, dl_q, side;
    logic              dl_occ;
    logic              side_vld, side_last;
    logic [DATA_W-1:0] side_a;
    logic [HALF_W-1:0] side_blo;

    assign cmd_acc  = cmd_valid & cmd_ready;
    assign cmd_bad  = cmd_acc & ~mode_legal(cmd_mode);
    assign cmd_go   = cmd_acc & mode_legal(cmd_mode) & (cmd_len != '0);
    assign acc      = in_valid & in_ready;
    assign cnt_inc  = cnt_q + LEN_W'(1);
    assign acc_last = acc & (cnt_inc == len_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // DRAIN exits once neither the delay line nor the output register holds a valid tag
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc && mode_legal(cmd_mode))
                    state_d = (cmd_len == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN:   if (acc_last) state_d = ST_DRAIN;
            ST_DRAIN: if (!dl_occ && !out_valid) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_RUN:  in_ready = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Mode and direction only move in IDLE, so the pipeline is empty whenever they change
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_K2;
            intt_q <= 1'b0;
            len_q  <= '0;
            cnt_q  <= '0;
            err    <= 1'b0;
        end else begin
            err <= cmd_bad;
            if (cmd_go) begin
                mode_q <= cmd_mode;
                intt_q <= cmd_intt;
                len_q  <= cmd_len;
                cnt_q  <= '0;
            end else if (acc) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    assign add_mode  = mode_q;
    assign add_sel_1 = intt_q;

    // NTT: A and B-low wait SHIFT_LAT cycles to meet B-high, which the adder delays internally
    assign dl_d = (acc && !intt_q) ? {1'b1, acc_last, in_a, in_b[HALF_W-1:0]} : '0;

    adder1_delay_line #(
        .W      (DL_W),
        .DEPTH  (SHIFT_LAT),
        .VLD_BIT(DL_W - 1)
    ) u_dl (
        .clk(clk),
        .rst(rst),
        .d  (dl_d),
        .q  (dl_q),
        .occ(dl_occ)
    );

    always_comb begin
        side = dl_q;
        if (intt_q)
            side = {acc, acc_last, in_a, in_b[HALF_W-1:0]};
    end

    assign {side_vld, side_last, side_a, side_blo} = side;

    assign add_a = side_vld ? side_a : '0;
    assign add_b = {acc ? in_b[DATA_W-1:HALF_W] : {(DATA_W-HALF_W){1'b0}},
                    side_vld ? side_blo : {HALF_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= side_vld;
            out_last  <= side_vld & side_last;
            out_data  <= add_sum;
        end
    end

`ifdef ADDER1_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_elems  <= '0;
        end else begin
            if (busy && perf_cycles != '1)
                perf_cycles <= perf_cycles + 32'd1;
            if (out_valid && perf_elems != '1)
                perf_elems <= perf_elems + 32'd1;
        end
    end
`endif

endmodule

// File: doc/adder1_sched.md
Name: adder1_sched

Overview:
Batch scheduler for the shared 12/24-bit modular adder (K_2, K_4 and D modes).
- Accepts a command (mode, NTT/INTT, element count), then streams operand pairs into the adder.
- Drives the adder's mode and sel_1 and holds both stable for the whole batch.
- Compensates the adder's internal 6-cycle shift on the B-high lane in NTT direction, registers the result and flags the last element.
- Sits between the NTT/INTT top-level FSM and the adder instance.

Parameters:
DATA_W, 24, operand/result width
SHIFT_LAT, 6, B-high lane delay inside the adder when sel_1=0
LEN_W, 9, width of the batch element counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_mode  in  2  0=K_2, 1=K_4, 2=D, 3=illegal
cmd_intt  in  1  1=INTT (no B-high shift), 0=NTT
cmd_len  in  LEN_W  number of elements in batch
in_valid  in  1  operand pair valid
in_ready  out  1  scheduler accepts operands
in_a  in  DATA_W  operand A
in_b  in  DATA_W  operand B
add_a  out  DATA_W  to adder Adder1_a
add_b  out  DATA_W  to adder Adder1_b
add_sel_1  out  1  to adder sel_1 (= cmd_intt latched)
add_mode  out  2  to adder Adder_1_mode
add_sum  in  DATA_W  from adder Adder1_sum (combinational)
out_valid  out  1  result valid
out_data  out  DATA_W  registered result
out_last  out  1  last element of batch
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at batch completion
err  out  1  one-cycle pulse on illegal mode command

Behaviour:
- Reset values:
  - All outputs 0 except cmd_ready=1.
  - State IDLE, counters and delay-line valid bits cleared.
  - Latched mode=0 and latched intt=0, so add_mode=0 and add_sel_1=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: cmd_ready=1, in_ready=0.
  - Command with mode 3: err pulses next cycle, state stays IDLE, latched mode/intt unchanged.
  - Command with cmd_len=0: go to DONE.
  - Any other command: latch mode, intt and len, clear accepted count, go to RUN.
- RUN: cmd_ready=0, in_ready=1. Each in_valid&in_ready increments the accepted count. When the count reaches len, go to DRAIN; the last pair is tagged last.
- Lane alignment:
  - NTT (intt=0): add_b[23:12] = in_b[23:12] undelayed. add_a and add_b[11:0] come from a SHIFT_LAT-deep delay line, so the adder combines the triplet accepted in the same cycle.
  - INTT (intt=1): all lanes pass straight through.
- A valid/last tag travels with each element through the delay line (depth SHIFT_LAT in NTT, 0 in INTT).
- Output register: out_data <= add_sum, out_valid <= tag, out_last <= last tag.
  - Latency from acceptance to out_valid: SHIFT_LAT+1 (7) in NTT, 1 in INTT.
- Idle lanes:
  - add_a and add_b[11:0] are 0 when no valid element is in the delay line at the adder side.
  - add_b[23:12] is 0 when in_valid&in_ready is low.
- DRAIN: in_ready=0. Stay until no valid tag remains in the delay line or the output register, i.e. the cycle after out_last. Then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Mode/sel_1 change happens only in IDLE, so the pipeline is always empty at a change.
- in_valid is ignored outside RUN. Bubbles in RUN are allowed; they propagate as invalid tags.
- Reset mid-batch: the next cycle is IDLE with all tags cleared. No out_valid or done until a new command.

Optional Feature:
ADDER1_SCHED_PERF_EN
- With macro: two extra outputs.
  - perf_cycles[31:0]: count of busy cycles, saturating.
  - perf_elems[31:0]: count of out_valid results, saturating.
  - Both cleared only by rst.
- Without macro: ports and counters absent, behaviour otherwise identical.

Decomposition:
- Shared package adder_pkg holds:
  - Mode constants MODE_K2=2'd0, MODE_K4=2'd1, MODE_D=2'd2.
  - Kq=3329, Dq=8380417, SHIFT_LAT=6.
  - The state encoding.
- One sub-module, adder1_delay_line: parameterised width/depth shift register with sync reset and depth-0 bypass. Used once for {valid, last, a, b_low} data.

Test Plan:
- K_2 NTT, len=1, in_a={12'd3000,12'd500}, in_b=0 -> out_data={12'd171,12'd2500} with out_valid=out_last=1 exactly 7 cycles after acceptance; done next-but-one cycle.
- D INTT, len=2, back-to-back:
  - pair 1: in_a=24'd8000000, in_b=24'd1000000 -> out_data=24'd619583, 1 cycle after acceptance.
  - pair 2: in_a=24'd5, in_b=24'd7 -> out_data=24'd12, out_last=1 on pair 2.
- K_4 NTT, len=4, in_valid toggled 1/0 -> 4 results, each 7 cycles after its acceptance; gaps preserved; in_ready low once count=4.
- cmd_mode=3 -> err pulse, state IDLE, busy=0, add_mode unchanged; cmd_len=0 with mode 1 -> done pulse with no out_valid.
- rst asserted mid-batch (NTT, 3 of 5 accepted) -> no out_valid afterwards; cmd_ready=1, busy=0 the cycle after rst.
